tx8_select_sequencer: RTL and testbench

//  Upstream driver for the 8-channel transmission stage: accepts one byte per frame over valid/ready,

---
 rtl/tx8_pkg.sv | 21 ++
 rtl/tx8_dwell_counter.sv | 46 ++++
 rtl/tx8_select_sequencer.sv | 156 +++++++++++++++
 tb/tb_tx8_select_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx8_pkg.sv
// Shared types and constants for the 8-channel select sequencer.
package tx8_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;

  localparam logic [SEL_W-1:0] SEL_FIRST = 3'b000;
  localparam logic [SEL_W-1:0] SEL_LAST  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // True when the select code is the final code of a frame.
  function automatic logic is_last_code(input logic [SEL_W-1:0] code);
    return (code == SEL_LAST);
  endfunction

endpackage

// File: rtl/tx8_dwell_counter.sv
// Saturating up-counter with synchronous load-to-zero and terminal-count flags.
// Counts 0..LIMIT-1 while enabled and holds at LIMIT-1 (no wrap).
// tc reflects the current count; tc_next reflects the count after the next edge.
module tx8_dwell_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc,
  output logic tc_next
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc      = (count_q == TC_VAL);
  assign tc_next = (count_d == TC_VAL);

  // Next-count: load wins, otherwise increment until terminal count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tx8_select_sequencer.sv
// Accepts one byte per frame, holds it on iData and steps {A,B,C} through
// 000..111 with a fixed dwell per code, followed by an idle gap.
module tx8_select_sequencer
  import tx8_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int GAP_CYCLES   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] iData,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              sel_valid,
  output logic              busy,
  output logic              frame_done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              in_ready_q, in_ready_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic accept;
  logic dwell_load, dwell_en, dwell_tc, dwell_tc_next;
  logic frame_end;
  logic gap_load, gap_en, gap_tc, gap_tc_next;
  logic gap_unused_s;

  assign accept    = in_valid && in_ready_q;
  assign frame_end = (state_q == ST_SEND) && dwell_tc && is_last_code(sel_q);

  // Dwell restarts on every accepted byte and after each completed code.
  assign dwell_en   = (state_q == ST_SEND);
  assign dwell_load = accept || ((state_q == ST_SEND) && dwell_tc);

  // Gap timer starts from zero as the last code finishes.
  assign gap_en   = (state_q == ST_GAP);
  assign gap_load = frame_end;

  tx8_dwell_counter #(
    .LIMIT (DWELL_CYCLES)
  ) u_dwell (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dwell_load),
    .en      (dwell_en),
    .tc      (dwell_tc),
    .tc_next (dwell_tc_next)
  );

  generate
    if (GAP_CYCLES > 0) begin : g_gap
      tx8_dwell_counter #(
        .LIMIT (GAP_CYCLES)
      ) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .en      (gap_en),
        .tc      (gap_tc),
        .tc_next (gap_tc_next)
      );
    end else begin : g_no_gap
      // GAP state is never entered; tie the timer off.
      assign gap_tc      = 1'b1;
      assign gap_tc_next = 1'b1;
    end
  endgenerate

  // The gap look-ahead flag and timer controls are not needed by the FSM.
  assign gap_unused_s = ^{gap_tc_next, gap_load, gap_en};

  // Next-state, data/select update and look-ahead of all registered outputs.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = in_data;
          sel_d   = SEL_FIRST;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (dwell_tc) begin
          if (is_last_code(sel_q)) begin
            state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_tc) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d   = (state_d == ST_IDLE);
    sel_valid_d  = (state_d == ST_SEND);
    busy_d       = (state_d != ST_IDLE);
    // Flag the last dwell cycle of the last code one cycle ahead.
    frame_done_d = (state_d == ST_SEND) && is_last_code(sel_d) && dwell_tc_next;
  end

  // FSM state, held byte, select code and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      data_q       <= 8'h00;
      sel_q        <= 3'b000;
      in_ready_q   <= 1'b0;
      sel_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
      in_ready_q   <= in_ready_d;
      sel_valid_q  <= sel_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign iData      = data_q;
  assign A          = sel_q[2];
  assign B          = sel_q[1];
  assign C          = sel_q[0];
  assign sel_valid  = sel_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_tx8_select_sequencer.sv
// Scoreboard bench: instance 0 uses DWELL=4/GAP=10, instance 1 uses DWELL=1/GAP=0.
module tb_tx8_select_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid [2];
  logic [7:0] in_data  [2];
  logic       rdy      [2];
  logic       qe       [2];
  logic [2:0] code_w   [2];
  logic       busy_w   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int DW = (g == 0) ? 4 : 1;
    localparam int GP = (g == 0) ? 10 : 0;

    logic       in_ready_s, a_s, b_s, c_s, sel_valid_s, busy_s, frame_done_s;
    logic [7:0] idata_s;

    tx8_select_sequencer #(
      .DWELL_CYCLES (DW),
      .GAP_CYCLES   (GP)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_data    (in_data[g]),
      .in_ready   (in_ready_s),
      .iData      (idata_s),
      .A          (a_s),
      .B          (b_s),
      .C          (c_s),
      .sel_valid  (sel_valid_s),
      .busy       (busy_s),
      .frame_done (frame_done_s)
    );

    logic [11:0] sb_q [$];
    logic [11:0] exp_item;
    int          q_n = 0;
    int          gap_cnt = 0;
    logic        in_gap = 1'b0;
    logic        expect_start = 1'b0;
    logic [7:0]  last_data = 8'h00;

    assign rdy[g]    = in_ready_s;
    assign qe[g]     = (q_n == 0);
    assign code_w[g] = {a_s, b_s, c_s};
    assign busy_w[g] = busy_s;

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
      if (!rst_n) begin
        sb_q.delete();
        in_gap       = 1'b0;
        expect_start = 1'b0;
        check_eq($sformatf("d%0d_rst_ready", g), {31'd0, in_ready_s}, 32'd0);
        check_eq($sformatf("d%0d_rst_outs", g),
                 {20'd0, idata_s, a_s, b_s, c_s, sel_valid_s},
                 32'd0);
        check_eq($sformatf("d%0d_rst_flags", g), {30'd0, busy_s, frame_done_s}, 32'd0);
      end else begin
        if (expect_start) begin
          check_eq($sformatf("d%0d_start_latency", g), {31'd0, sel_valid_s}, 32'd1);
          expect_start = 1'b0;
        end
        if (sel_valid_s) begin
          check_eq($sformatf("d%0d_send_flags", g), {30'd0, in_ready_s, busy_s}, 32'd1);
          if (sb_q.size() == 0) begin
            check_eq($sformatf("d%0d_unexpected_code", g), {31'd0, sel_valid_s}, 32'd0);
          end else begin
            exp_item = sb_q.pop_front();
            check_eq($sformatf("d%0d_data_code", g),
                     {21'd0, idata_s, a_s, b_s, c_s}, {21'd0, exp_item[10:0]});
            check_eq($sformatf("d%0d_frame_done", g),
                     {31'd0, frame_done_s}, {31'd0, exp_item[11]});
            if (exp_item[11]) begin
              in_gap    = 1'b1;
              gap_cnt   = 0;
              last_data = exp_item[10:3];
            end
          end
        end else begin
          check_eq($sformatf("d%0d_fd_idle", g), {31'd0, frame_done_s}, 32'd0);
          if (in_ready_s) begin
            check_eq($sformatf("d%0d_idle_busy", g), {31'd0, busy_s}, 32'd0);
          end
          if (in_gap) begin
            if (in_ready_s) begin
              check_eq($sformatf("d%0d_gap_len", g), gap_cnt, GP);
              in_gap = 1'b0;
            end else begin
              gap_cnt++;
              check_eq($sformatf("d%0d_gap_hold", g),
                       {20'd0, idata_s, a_s, b_s, c_s, busy_s},
                       {20'd0, last_data, 3'b111, 1'b1});
              if (gap_cnt > GP + 1) begin
                check_eq($sformatf("d%0d_gap_timeout", g), gap_cnt, GP);
                in_gap = 1'b0;
              end
            end
          end
        end
        // Handshake seen now is taken at the next rising edge.
        if (in_valid[g] && in_ready_s) begin
          for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < DW; d++) begin
              sb_q.push_back({((c == 7) && (d == DW - 1)), in_data[g], 3'(c)});
            end
          end
          expect_start = 1'b1;
        end
      end
      q_n = sb_q.size();
    end
  end

  // Wait (bounded) until the instance is ready; the byte is taken at the next edge.
  task automatic wait_accept(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("d%0d_accept_timeout", g), 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input int g, input logic [7:0] d);
    in_valid[g] = 1'b1;
    in_data[g]  = d;
    wait_accept(g);
    in_valid[g] = 1'b0;
  endtask

  task automatic send_two(input int g, input logic [7:0] d0, input logic [7:0] d1);
    in_valid[g] = 1'b1;
    in_data[g]  = d0;
    wait_accept(g);
    in_data[g]  = d1;
    wait_accept(g);
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rdy[g] && qe[g]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("d%0d_idle_timeout", g), 32'd0, 32'd1);
  endtask

  task automatic wait_code(input int g, input logic [2:0] code);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (code_w[g] == code) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq($sformatf("d%0d_code_timeout", g), 32'd0, 32'd1);
  endtask

  initial begin
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    in_data[0]  = 8'h00;
    in_data[1]  = 8'h00;

    // Reset with a byte offered: nothing may be accepted while held.
    #2 rst_n = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h0F;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single frame.
    send_one(0, 8'h0F);
    wait_idle(0);

    // Back-to-back frames with in_valid held.
    send_two(0, 8'h0F, 8'hAA);
    wait_idle(0);

    // Input byte toggled while the frame is sending.
    send_one(0, 8'h3C);
    for (int i = 0; i < 20; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    wait_idle(0);

    // Reset while code 011 is on the outputs.
    send_one(0, 8'h55);
    wait_code(0, 3'b011);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("d0_async_rst", {28'd0, code_w[0], busy_w[0]}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_one(0, 8'h81);
    wait_idle(0);

    // DWELL=1, GAP=0 instance: single and back-to-back frames.
    send_one(1, 8'hC3);
    wait_idle(1);
    send_two(1, 8'h18, 8'hE7);
    wait_idle(1);

    repeat (3) @(negedge clk);
    check_eq("d0_drain", {31'd0, qe[0]}, 32'd1);
    check_eq("d1_drain", {31'd0, qe[1]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
